// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, drives IMEM, fills the IF/ID register.
// Optional perf counters are enabled with `define IF_PERF_CNT_EN.
module if_stage #(
    parameter int unsigned    DATA_WIDTH = 32,
    parameter logic [31:0]    NOP_INSTR  = 32'h0000_0013,
    parameter int unsigned    IMEM_DEPTH = 100
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] boot_add,
    output logic [DATA_WIDTH-1:0] A_IMEM,
    input  logic [DATA_WIDTH-1:0] Instr_in,
    input  logic                  stall_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    output logic [DATA_WIDTH-1:0] IF_instr_o,
    output logic [DATA_WIDTH-1:0] IF_pc_o,
    output logic                  IF_valid_o,
    output logic                  misalign_o,
    output logic                  oor_o,
    output logic                  halted_o
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]           fetch_cnt_o,
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           flush_cnt_o
`endif
);

    localparam logic [DATA_WIDTH-1:0] EBREAK  = DATA_WIDTH'(32'h0010_0073);
    localparam logic [DATA_WIDTH-1:0] OOR_LIM = DATA_WIDTH'(IMEM_DEPTH * 4);
    localparam logic [DATA_WIDTH-1:0] NOP_W   = DATA_WIDTH'(NOP_INSTR);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic [DATA_WIDTH-1:0] ipc_q, ipc_d;
    logic                  valid_q, valid_d;
    logic                  mis_q, mis_d;
    logic                  redir_act;
    logic                  stall_act;
    logic                  fetch_act;

    assign A_IMEM     = pc_q;
    assign oor_o      = (pc_q >= OOR_LIM);
    assign IF_instr_o = instr_q;
    assign IF_pc_o    = ipc_q;
    assign IF_valid_o = valid_q;
    assign misalign_o = mis_q;
    assign halted_o   = (state_q == ST_HALT);

    // Redirect is honoured in RUN and HALT; BOOT ignores all control inputs.
    assign redir_act = redirect_i && (state_q != ST_BOOT);
    assign stall_act = stall_i && !redir_act && (state_q == ST_RUN);
    assign fetch_act = (state_q == ST_RUN) && !redirect_i && !stall_i && !oor_o;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        ipc_d   = ipc_q;
        valid_d = valid_q;
        mis_d   = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                pc_d    = boot_add;
                instr_d = NOP_W;
                ipc_d   = '0;
                valid_d = 1'b0;
                state_d = ST_RUN;
            end
            ST_RUN, ST_HALT: begin
                if (redir_act) begin
                    pc_d    = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
                    instr_d = NOP_W;
                    ipc_d   = '0;
                    valid_d = 1'b0;
                    mis_d   = |redirect_pc_i[1:0];
                    state_d = ST_RUN;
                end else if (!stall_i) begin
                    if (state_q == ST_HALT || oor_o) begin
                        instr_d = NOP_W;
                        ipc_d   = '0;
                        valid_d = 1'b0;
                        if (state_q == ST_RUN) pc_d = pc_q + DATA_WIDTH'(4);
                    end else begin
                        instr_d = Instr_in;
                        ipc_d   = pc_q;
                        valid_d = 1'b1;
                        if (Instr_in == EBREAK) state_d = ST_HALT;
                        else pc_d = pc_q + DATA_WIDTH'(4);
                    end
                end
            end
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_BOOT;
            pc_q    <= '0;
            instr_q <= NOP_W;
            ipc_q   <= '0;
            valid_q <= 1'b0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            ipc_q   <= ipc_d;
            valid_q <= valid_d;
            mis_q   <= mis_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fcnt_q, fcnt_d;
    logic [31:0] scnt_q, scnt_d;
    logic [31:0] rcnt_q, rcnt_d;

    // Counters saturate rather than wrap.
    always_comb begin
        fcnt_d = fcnt_q;
        scnt_d = scnt_q;
        rcnt_d = rcnt_q;
        if (fetch_act && fcnt_q != '1) fcnt_d = fcnt_q + 32'd1;
        if (stall_act && scnt_q != '1) scnt_d = scnt_q + 32'd1;
        if (redir_act && rcnt_q != '1) rcnt_d = rcnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt_q <= '0;
            scnt_q <= '0;
            rcnt_q <= '0;
        end else begin
            fcnt_q <= fcnt_d;
            scnt_q <= scnt_d;
            rcnt_q <= rcnt_d;
        end
    end

    assign fetch_cnt_o = fcnt_q;
    assign stall_cnt_o = scnt_q;
    assign flush_cnt_o = rcnt_q;
`else
    logic unused_perf;
    assign unused_perf = fetch_act ^ stall_act;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a cycle-level behavioural model.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] EBR = 32'h0010_0073;
    localparam logic [31:0] LIM = 32'd400;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] boot_add = '0;
    logic [31:0] A_IMEM;
    logic [31:0] Instr_in;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] IF_instr_o;
    logic [31:0] IF_pc_o;
    logic        IF_valid_o;
    logic        misalign_o;
    logic        oor_o;
    logic        halted_o;

    logic [31:0] mem [128];

    int checks = 0;
    int failures = 0;

    logic [31:0] m_pc, m_instr, m_ipc;
    logic        m_valid, m_mis, m_halt, m_boot;

    always #5 clk = ~clk;

    assign Instr_in = (A_IMEM < 32'd512) ? mem[A_IMEM[8:2]] : 32'h0000_0033;

    if_stage dut (
        .clk          (clk),
        .rst          (rst),
        .boot_add     (boot_add),
        .A_IMEM       (A_IMEM),
        .Instr_in     (Instr_in),
        .stall_i      (stall_i),
        .redirect_i   (redirect_i),
        .redirect_pc_i(redirect_pc_i),
        .IF_instr_o   (IF_instr_o),
        .IF_pc_o      (IF_pc_o),
        .IF_valid_o   (IF_valid_o),
        .misalign_o   (misalign_o),
        .oor_o        (oor_o),
        .halted_o     (halted_o)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] imem(input logic [31:0] a);
        return (a < 32'd512) ? mem[a[8:2]] : 32'h0000_0033;
    endfunction

    task automatic model_reset();
        m_pc = '0; m_instr = NOP; m_ipc = '0; m_valid = 0;
        m_mis = 0; m_halt = 0; m_boot = 1;
    endtask

    task automatic bubble();
        m_instr = NOP; m_ipc = '0; m_valid = 0;
    endtask

    // One clock of architectural behaviour, from the pre-edge values.
    task automatic model_step();
        logic [31:0] w;
        m_mis = 0;
        if (m_boot) begin
            m_pc = boot_add; bubble(); m_boot = 0;
        end else if (redirect_i) begin
            m_pc = redirect_pc_i & ~32'd3; bubble();
            m_mis = (redirect_pc_i[1:0] != 2'b00); m_halt = 0;
        end else if (stall_i) begin
        end else if (m_halt) begin
            bubble();
        end else if (m_pc >= LIM) begin
            bubble(); m_pc = m_pc + 32'd4;
        end else begin
            w = imem(m_pc);
            m_instr = w; m_ipc = m_pc; m_valid = 1;
            if (w == EBR) m_halt = 1;
            else m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all(input string ph);
        check({ph, ".a_imem"}, A_IMEM, m_pc);
        check({ph, ".instr"}, IF_instr_o, m_instr);
        check({ph, ".ipc"}, IF_pc_o, m_ipc);
        check({ph, ".valid"}, 32'(IF_valid_o), 32'(m_valid));
        check({ph, ".mis"}, 32'(misalign_o), 32'(m_mis));
        check({ph, ".oor"}, 32'(oor_o), 32'(m_pc >= LIM));
        check({ph, ".halt"}, 32'(halted_o), 32'(m_halt));
    endtask

    task automatic cyc(input logic s, input logic r, input logic [31:0] rp,
                       input string ph);
        stall_i = s; redirect_i = r; redirect_pc_i = rp;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all(ph);
    endtask

    task automatic do_reset(input logic [31:0] ba);
        @(posedge clk);
        #2 rst = 1'b1;
        model_reset();
        #1 compare_all("reset");
        @(negedge clk);
        boot_add = ba;
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = $urandom();
            if (mem[i] == EBR) mem[i] = 32'h0000_0033;
        end
        mem[0] = 32'h0050_0113;
        mem[1] = 32'h00A0_0193;
        mem[2] = 32'h0031_00B3;
        mem[3] = EBR;
        model_reset();

        do_reset(32'h0);
        cyc(1, 1, 32'h40, "boot");
        cyc(0, 0, 0, "f0");
        cyc(0, 0, 0, "f4");
        cyc(1, 0, 0, "st1");
        cyc(1, 0, 0, "st2");
        cyc(0, 0, 0, "f8");
        cyc(0, 0, 0, "ebrk");
        cyc(0, 0, 0, "halt1");
        cyc(1, 0, 0, "halt2");
        cyc(0, 1, 32'h0, "unhalt");
        cyc(1, 1, 32'h20, "redst");
        cyc(0, 0, 0, "f20");
        cyc(0, 1, 32'h22, "mis");
        cyc(0, 0, 0, "mis2");
        cyc(0, 1, 32'h18C, "nearoor");
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, "oor");
        cyc(0, 1, 32'hFFFF_FFFC, "wrap");
        cyc(0, 0, 0, "wrap0");
        cyc(0, 0, 0, "wrap4");

        mem[3] = 32'h0000_0033;
        for (int i = 0; i < 4; i++) mem[$urandom_range(4, 127)] = EBR;
        for (int i = 0; i < 3000; i++) begin
            logic        r;
            logic [31:0] rp;
            r  = ($urandom_range(0, 99) < 8);
            rp = $urandom_range(0, 511);
            if ($urandom_range(0, 19) == 0) rp = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            cyc($urandom_range(0, 99) < 20, r, rp, "rnd");
            if (i % 700 == 350) do_reset($urandom_range(0, 127) << 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
